dsp_mac_pipe: RTL and testbench

DSP_MAC_PIPE -- requirements
Module: DSP

---
 rtl/dsp_mac_pipe.sv | 103 ++++++++++
 tb/tb_dsp_mac_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_mac_pipe
//  Description : 4-stage pre-subtract / multiply / accumulate pipe,
//                P = (load ? rrC : P) + (A - D) * B, with a marker delay line.
//  Revision    : 1.0  initial release
// ============================================================================
module dsp_mac_pipe #(
    parameter int AW = 8,
    parameter int BW = 8,
    parameter int PW = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 idelay,
    input  logic [AW-1:0]        A,
    input  logic signed [BW-1:0] B,
    input  logic signed [PW-1:0] rrC,
    input  logic [AW-1:0]        D,
    output logic signed [PW-1:0] P,
    output logic                 odelay_pre1,
    output logic                 odelay
);

    localparam int MW = AW + BW + 1;

    // Stage 1: input registers
    logic [AW-1:0]        a_q;
    logic [AW-1:0]        d_q;
    logic signed [BW-1:0] b1_q;
    logic                 ld1_q;
    logic                 id1_q;

    // Stage 2: pre-subtract
    logic signed [AW:0]   ad_q;
    logic signed [AW:0]   ad_d;
    logic signed [BW-1:0] b2_q;
    logic                 ld2_q;
    logic                 id2_q;

    // Stage 3: multiply
    logic signed [MW-1:0] m_q;
    logic signed [MW-1:0] m_d;
    logic                 ld3_q;
    logic                 id3_q;

    // Stage 4: accumulate
    logic signed [PW-1:0] p_q;
    logic signed [PW-1:0] p_d;
    logic signed [PW-1:0] m_ext;
    logic                 id4_q;

    always_comb begin
        ad_d  = $signed({1'b0, a_q}) - $signed({1'b0, d_q});
        // Both operands widened to the full product width so the signed
        // multiply cannot lose the top bit of (A-D)*B.
        m_d   = MW'(ad_q) * MW'(b2_q);
        m_ext = PW'(m_q);
        // rrC is taken live here, on the edge that updates P.
        p_d   = ld3_q ? (rrC + m_ext) : (p_q + m_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            d_q   <= '0;
            b1_q  <= '0;
            ld1_q <= 1'b0;
            id1_q <= 1'b0;
            ad_q  <= '0;
            b2_q  <= '0;
            ld2_q <= 1'b0;
            id2_q <= 1'b0;
            m_q   <= '0;
            ld3_q <= 1'b0;
            id3_q <= 1'b0;
            p_q   <= '0;
            id4_q <= 1'b0;
        end else begin
            a_q   <= A;
            d_q   <= D;
            b1_q  <= B;
            ld1_q <= load;
            id1_q <= idelay;
            ad_q  <= ad_d;
            b2_q  <= b1_q;
            ld2_q <= ld1_q;
            id2_q <= id1_q;
            m_q   <= m_d;
            ld3_q <= ld2_q;
            id3_q <= id2_q;
            p_q   <= p_d;
            id4_q <= id3_q;
        end
    end

    assign P           = p_q;
    assign odelay_pre1 = id3_q;
    assign odelay      = id4_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_mac_pipe
//  Description : Self-checking bench for dsp_mac_pipe: per-cycle model plus
//                hand-computed pinned expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dsp_mac_pipe;

    localparam int AW = 8;
    localparam int BW = 8;
    localparam int PW = 24;
    localparam int HN = 4096;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 load;
    logic                 idelay;
    logic [AW-1:0]        A;
    logic signed [BW-1:0] B;
    logic signed [PW-1:0] rrC;
    logic [AW-1:0]        D;
    logic signed [PW-1:0] P;
    logic                 odelay_pre1;
    logic                 odelay;

    dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .idelay      (idelay),
        .A           (A),
        .B           (B),
        .rrC         (rrC),
        .D           (D),
        .P           (P),
        .odelay_pre1 (odelay_pre1),
        .odelay      (odelay)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    bit seen_reset = 1'b0;

    // Sample history indexed by the edge that captured it.
    bit h_ld [HN];
    bit h_id [HN];
    int h_pr [HN];

    logic [PW-1:0] exp_p   = '0;
    logic          exp_pre = 1'b0;
    logic          exp_od  = 1'b0;

    typedef struct {
        int            e;
        int            kind;
        logic [PW-1:0] val;
    } pin_t;
    pin_t pins[$];

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, edge_cnt, act, req);
        end
    endtask

    // Model: the sample captured at edge s lands in P at edge s+3; a reset
    // at edge k wipes every sample captured at k-3..k.
    always @(posedge clk) begin
        int s;
        edge_cnt++;
        if (edge_cnt < HN) begin
            if (rst) begin
                seen_reset = 1'b1;
                for (int j = edge_cnt - 3; j <= edge_cnt; j++) begin
                    if (j >= 0) begin
                        h_ld[j] = 1'b0;
                        h_id[j] = 1'b0;
                        h_pr[j] = 0;
                    end
                end
                exp_p   = '0;
                exp_pre = 1'b0;
                exp_od  = 1'b0;
            end else begin
                h_ld[edge_cnt] = load;
                h_id[edge_cnt] = idelay;
                h_pr[edge_cnt] = (int'(A) - int'(D)) * int'(B);
                s = edge_cnt - 3;
                if (s >= 0) begin
                    if (h_ld[s]) exp_p = rrC + PW'(h_pr[s]);
                    else         exp_p = exp_p + PW'(h_pr[s]);
                    exp_od = h_id[s];
                end
                exp_pre = (edge_cnt >= 2) ? h_id[edge_cnt-2] : 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (seen_reset) begin
            chk("model_P", P, exp_p);
            chk("model_odelay", PW'(odelay), PW'(exp_od));
            chk("model_odelay_pre1", PW'(odelay_pre1), PW'(exp_pre));
        end
        for (int i = pins.size() - 1; i >= 0; i--) begin
            if (pins[i].e == edge_cnt) begin
                case (pins[i].kind)
                    0:       chk("pin_P", P, pins[i].val);
                    1:       chk("pin_odelay", PW'(odelay), pins[i].val);
                    default: chk("pin_odelay_pre1", PW'(odelay_pre1), pins[i].val);
                endcase
                pins.delete(i);
            end
        end
    end

    task automatic step(input bit r, input bit ld, input bit id, input int a, input int b, input int d);
        @(negedge clk);
        rst    = r;
        load   = ld;
        idelay = id;
        A      = AW'(a);
        B      = BW'(b);
        D      = AW'(d);
    endtask

    // kind: 0 = P, 1 = odelay, 2 = odelay_pre1; checked when edge_cnt hits now+ofs
    task automatic pin(input int ofs, input int kind, input logic [PW-1:0] v);
        pin_t p;
        p.e    = edge_cnt + ofs;
        p.kind = kind;
        p.val  = v;
        pins.push_back(p);
    endtask

    task automatic flush();
        repeat (4) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        int sum;
        int a, b, d;
        rst = 1'b1; load = 1'b0; idelay = 1'b0;
        A = '0; B = '0; D = '0; rrC = '0;
        repeat (2) @(negedge clk);

        // Reset state, then zeroed stages drain with P held at 0
        step(1'b1, 1'b1, 1'b1, 255, 127, 0);
        pin(1, 0, '0); pin(1, 1, '0); pin(1, 2, '0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 0);
        pin(3, 0, '0);
        flush();

        // Preload then two accumulates
        rrC = PW'(1000);
        step(1'b0, 1'b1, 1'b0, 200, 3, 128);    pin(4, 0, PW'(1216));
        step(1'b0, 1'b0, 1'b0, 0, -1, 128);     pin(4, 0, PW'(1344));
        step(1'b0, 1'b0, 1'b0, 0, -128, 128);   pin(4, 0, PW'(17728));
        flush();

        // Wrap past the positive maximum
        rrC = 24'h7FFFFF;
        step(1'b0, 1'b1, 1'b0, 255, 127, 128);  pin(4, 0, 24'h803F00);
        flush();

        // Product extremes, back-to-back loads
        rrC = '0;
        step(1'b0, 1'b1, 1'b0, 0, -128, 255);   pin(4, 0, PW'(32640));
        step(1'b0, 1'b1, 1'b0, 255, -128, 0);   pin(4, 0, 24'hFF8080);
        flush();

        // Row of 8, marker on the last sample
        rrC = PW'(5000);
        sum = 5000;
        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, 255));
            d = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255)) - 128;
            sum += (a - d) * b;
            step(1'b0, i == 0, i == 7, a, b, d);
        end
        pin(2, 2, '0); pin(3, 2, PW'(1)); pin(3, 1, '0);
        pin(4, 1, PW'(1)); pin(4, 0, PW'(sum));
        flush();

        // Reset with a marked sample in flight
        rrC = '0;
        step(1'b0, 1'b1, 1'b1, 200, 3, 128);
        pin(3, 2, '0); pin(4, 1, '0); pin(4, 0, '0);
        step(1'b0, 1'b0, 1'b0, 50, 2, 10);
        step(1'b1, 1'b0, 1'b0, 77, 5, 3);
        rrC = PW'(7);
        step(1'b0, 1'b1, 1'b0, 130, 5, 128);    pin(4, 0, PW'(17));
        flush();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rrC = PW'($urandom);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)));
        end
        flush();
        repeat (2) @(negedge clk);

        checks++;
        if (pins.size() != 0) begin
            failures++;
            $display("FAIL pins_unvisited actual=%0d required=0", pins.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
